// File: rtl/tmds_encoder.sv
// DVI TMDS 8b/10b encoder for one colour channel with running DC-disparity tracking.
// Define TMDS_PIPE2_EN to register the transition-minimised word before the DC-balance stage (latency 2).
module tmds_encoder (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       de,
  input  logic [1:0] ctrl,
  input  logic [7:0] data_in,
  output logic [9:0] tmds_out,
  output logic [4:0] disp_cnt
);

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  logic [3:0] n1d;
  logic       use_xnor;
  logic [8:0] qm_a;

  always_comb begin
    n1d = 4'd0;
    for (int i = 0; i < 8; i++) n1d = n1d + 4'(data_in[i]);
    use_xnor = (n1d > 4'd4) || (n1d == 4'd4 && !data_in[0]);
    qm_a = 9'd0;
    qm_a[0] = data_in[0];
    for (int i = 1; i < 8; i++)
      qm_a[i] = use_xnor ? ~(qm_a[i-1] ^ data_in[i]) : (qm_a[i-1] ^ data_in[i]);
    qm_a[8] = ~use_xnor;
  end

  logic [8:0] qm_b;
  logic       de_b;
  logic [1:0] ctrl_b;

`ifdef TMDS_PIPE2_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      qm_b   <= 9'd0;
      de_b   <= 1'b0;
      ctrl_b <= 2'b00;
    end else begin
      qm_b   <= qm_a;
      de_b   <= de;
      ctrl_b <= ctrl;
    end
  end
`else
  assign qm_b   = qm_a;
  assign de_b   = de;
  assign ctrl_b = ctrl;
`endif

  // Disparity kept as 5-bit two's complement; all sums wrap mod 32, |cnt|<=10 by construction.
  logic [4:0] cnt;
  logic [3:0] n1;
  logic [4:0] diff;
  logic [9:0] sym_nx;
  logic [4:0] cnt_nx;
  logic       cnt_zero, cnt_pos, cnt_neg;

  always_comb begin
    n1 = 4'd0;
    for (int i = 0; i < 8; i++) n1 = n1 + 4'(qm_b[i]);
    diff     = {n1, 1'b0} - 5'd8;   // n1 - n0
    cnt_zero = (cnt == 5'd0);
    cnt_neg  = cnt[4];
    cnt_pos  = !cnt[4] && !cnt_zero;
    sym_nx   = CTRL_00;
    cnt_nx   = 5'd0;
    if (!de_b) begin
      case (ctrl_b)
        2'b00:   sym_nx = CTRL_00;
        2'b01:   sym_nx = CTRL_01;
        2'b10:   sym_nx = CTRL_10;
        default: sym_nx = CTRL_11;
      endcase
    end else if (cnt_zero || n1 == 4'd4) begin
      sym_nx = {~qm_b[8], qm_b[8], qm_b[8] ? qm_b[7:0] : ~qm_b[7:0]};
      cnt_nx = qm_b[8] ? cnt + diff : cnt - diff;
    end else if ((cnt_pos && n1 > 4'd4) || (cnt_neg && n1 < 4'd4)) begin
      sym_nx = {1'b1, qm_b[8], ~qm_b[7:0]};
      cnt_nx = cnt + {3'b000, qm_b[8], 1'b0} - diff;
    end else begin
      sym_nx = {1'b0, qm_b[8], qm_b[7:0]};
      cnt_nx = cnt - {3'b000, ~qm_b[8], 1'b0} + diff;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tmds_out <= CTRL_00;
      cnt      <= 5'd0;
    end else begin
      tmds_out <= sym_nx;
      cnt      <= cnt_nx;
    end
  end

  assign disp_cnt = cnt;

endmodule

// File: tb/tb_tmds_encoder.sv
// Scoreboard bench for tmds_encoder: directed symbols with hand-computed codes and disparity.
module tb_tmds_encoder;

`ifdef TMDS_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic       de = 1'b0;
  logic [1:0] ctrl = 2'b00;
  logic [7:0] data_in = 8'h00;
  logic [9:0] tmds_out;
  logic [4:0] disp_cnt;

  tmds_encoder dut (
    .clk_in(clk_in), .rst_in(rst_in), .de(de), .ctrl(ctrl),
    .data_in(data_in), .tmds_out(tmds_out), .disp_cnt(disp_cnt)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int         tag;
    logic [9:0] sym;
    int         dc;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Monitor: output after edge N is compared with every entry tagged N.
  exp_t e;
  always @(posedge clk_in) begin
    #1;
    while (sb.size() > 0 && sb[0].tag <= cyc) begin
      e = sb.pop_front();
      if (e.tag < cyc) begin
        n_checks++; n_fail++;
        $display("FAIL %s: entry for cycle %0d not checked (now %0d)", e.name, e.tag, cyc);
      end else begin
        n_checks++;
        if (tmds_out !== e.sym) begin
          n_fail++;
          $display("FAIL %s tmds_out: got 0x%03h expected 0x%03h (cycle %0d)", e.name, tmds_out, e.sym, cyc);
        end
        n_checks++;
        if ($signed(disp_cnt) != e.dc || $isunknown(disp_cnt)) begin
          n_fail++;
          $display("FAIL %s disp_cnt: got %0d expected %0d (cycle %0d)", e.name, $signed(disp_cnt), e.dc, cyc);
        end
      end
    end
  end

  task automatic sym(input logic d, input logic [1:0] c, input logic [7:0] x,
                     input logic [9:0] s, input int dc, input string nm);
    @(negedge clk_in);
    rst_in  = 1'b0;
    de      = d;
    ctrl    = c;
    data_in = x;
    sb.push_back('{cyc + LAT, s, dc, nm});
  endtask

  // Reset overrides whatever was in flight: drop later expectations, expect ctrl-00 symbols.
  task automatic do_reset(input string nm);
    int k;
    @(negedge clk_in);
    rst_in  = 1'b1;
    de      = 1'b1;
    data_in = 8'hFF;
    k = cyc + 1;
    while (sb.size() > 0 && sb[$].tag >= k) void'(sb.pop_back());
    sb.push_back('{k, 10'h354, 0, nm});
    if (LAT == 2) sb.push_back('{k + 1, 10'h354, 0, {nm, "_stage2"}});
  endtask

  initial begin
    do_reset("reset0");
    do_reset("reset1");
    // Control symbols during blanking
    sym(1'b0, 2'b00, 8'h00, 10'h354, 0, "ctrl00");
    sym(1'b0, 2'b01, 8'h5A, 10'h0AB, 0, "ctrl01");
    sym(1'b0, 2'b10, 8'hFF, 10'h154, 0, "ctrl10");
    sym(1'b0, 2'b11, 8'h00, 10'h2AB, 0, "ctrl11");
    // Zeros from cnt=0
    sym(1'b1, 2'b00, 8'h00, 10'h100, -8, "zero_a");
    sym(1'b1, 2'b00, 8'h00, 10'h3FF, 2,  "zero_b");
    sym(1'b1, 2'b00, 8'h00, 10'h100, -6, "zero_c");
    sym(1'b0, 2'b01, 8'hAB, 10'h0AB, 0,  "blank_clr");
    // 0xFF from cnt=0, then blanking clears cnt
    sym(1'b1, 2'b00, 8'hFF, 10'h200, -8, "ones");
    sym(1'b0, 2'b00, 8'h12, 10'h354, 0,  "blank_clr2");
    // ctrl ignored during active video, then each DC-balance branch
    sym(1'b1, 2'b11, 8'h00, 10'h100, -8, "ctrl_ign");
    sym(1'b1, 2'b10, 8'hFF, 10'h0FF, -2, "else_q8_0");
    sym(1'b1, 2'b00, 8'h55, 10'h133, -2, "balanced55");
    sym(1'b1, 2'b00, 8'h01, 10'h1FF, 6,  "else_q8_1");
    sym(1'b1, 2'b00, 8'h01, 10'h300, 0,  "invert_pos");
    sym(1'b1, 2'b00, 8'h00, 10'h100, -8, "from_zero");
    // Reset mid-line with cnt=-8
    do_reset("reset_mid");
    sym(1'b1, 2'b00, 8'h00, 10'h100, -8, "post_rst_a");
    sym(1'b1, 2'b00, 8'hFF, 10'h0FF, -2, "post_rst_b");
    sym(1'b1, 2'b00, 8'hAA, 10'h233, -2, "xnor_tie");
    sym(1'b0, 2'b00, 8'h00, 10'h354, 0,  "blank_end");
    sym(1'b1, 2'b00, 8'h00, 10'h100, -8, "restart");
    @(negedge clk_in);
    de = 1'b0;
    repeat (LAT + 3) @(negedge clk_in);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected symbols never seen, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
